// File: rtl/cpu_if_regs.sv
// AXI4-Lite register bank: version, scratch, LED control, cycle counter, sticky IRQ status/enable.
// Define CPU_IF_REGS_SLVERR_EN to answer unmapped offsets and writes to read-only registers with SLVERR.
//
// state  | meaning
// W_IDLE | collecting AW and W (either order); update fires when both are available
// W_RESP | bvalid asserted, waiting for bready
// R_IDLE | arready high, read data captured on the AR handshake
// R_DATA | rvalid asserted, rdata/rresp held until rready
module cpu_if_regs #(
    parameter int unsigned ADDR_W  = 12,
    parameter logic [31:0] VERSION = 32'h0001_0000,
    parameter int unsigned LED_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_if_awaddr,
    input  logic [2:0]        cpu_if_awprot,
    input  logic              cpu_if_awvalid,
    output logic              cpu_if_awready,
    input  logic [31:0]       cpu_if_wdata,
    input  logic [3:0]        cpu_if_wstrb,
    input  logic              cpu_if_wvalid,
    output logic              cpu_if_wready,
    output logic [1:0]        cpu_if_bresp,
    output logic              cpu_if_bvalid,
    input  logic              cpu_if_bready,
    input  logic [ADDR_W-1:0] cpu_if_araddr,
    input  logic [2:0]        cpu_if_arprot,
    input  logic              cpu_if_arvalid,
    output logic              cpu_if_arready,
    output logic [31:0]       cpu_if_rdata,
    output logic [1:0]        cpu_if_rresp,
    output logic              cpu_if_rvalid,
    input  logic              cpu_if_rready,
    input  logic              evt_in,
    output logic [LED_W-1:0]  led_ctrl,
    output logic              irq_out
);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    w_state_t          w_state_q, w_state_d;
    r_state_t          r_state_q, r_state_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q, w_held_d;
    logic [2:0]        wr_off_q, wr_off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [31:0]       scratch_q, scratch_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [31:0]       cnt_q;
    logic              irq_stat_q, irq_stat_d;
    logic              irq_en_q, irq_en_d;
    logic              irq_out_q;

    logic              aw_hs, w_hs, wr_fire, w1c;
    logic [2:0]        wr_off, rd_off;
    logic [31:0]       wr_data, rd_mux;
    logic [3:0]        wr_strb;
    logic              wr_err, rd_err;
    logic              unused_bits;

    assign unused_bits = ^{cpu_if_awprot, cpu_if_arprot, cpu_if_awaddr[1:0], cpu_if_awaddr[ADDR_W-1:5],
                           cpu_if_araddr[1:0], cpu_if_araddr[ADDR_W-1:5]};

    assign cpu_if_awready = (w_state_q == W_IDLE) && !aw_held_q;
    assign cpu_if_wready  = (w_state_q == W_IDLE) && !w_held_q;
    assign cpu_if_bvalid  = (w_state_q == W_RESP);
    assign cpu_if_bresp   = bresp_q;
    assign cpu_if_arready = (r_state_q == R_IDLE);
    assign cpu_if_rvalid  = (r_state_q == R_DATA);
    assign cpu_if_rdata   = rdata_q;
    assign cpu_if_rresp   = rresp_q;
    assign led_ctrl       = led_q;
    assign irq_out        = irq_out_q;

    // Same-cycle bypass lets a handshake fire the update immediately, so bvalid follows by one cycle.
    assign aw_hs   = cpu_if_awvalid && cpu_if_awready;
    assign w_hs    = cpu_if_wvalid && cpu_if_wready;
    assign wr_off  = aw_held_q ? wr_off_q : cpu_if_awaddr[4:2];
    assign wr_data = w_held_q ? wdata_q : cpu_if_wdata;
    assign wr_strb = w_held_q ? wstrb_q : cpu_if_wstrb;
    assign wr_fire = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign rd_off  = cpu_if_araddr[4:2];

`ifdef CPU_IF_REGS_SLVERR_EN
    assign wr_err = (wr_off == 3'd0) || (wr_off == 3'd3) || (wr_off[2:1] == 2'b11);
    assign rd_err = (rd_off[2:1] == 2'b11);
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        wr_off_d  = wr_off_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    wr_off_d  = cpu_if_awaddr[4:2];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = cpu_if_wdata;
                    wstrb_d  = cpu_if_wstrb;
                end
                if (wr_fire) begin
                    w_state_d = W_RESP;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
                end
            end
            W_RESP:  if (cpu_if_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        scratch_d = scratch_q;
        led_d     = led_q;
        irq_en_d  = irq_en_q;
        w1c       = 1'b0;
        if (wr_fire) begin
            case (wr_off)
                3'd1: for (int b = 0; b < 4; b++)
                          if (wr_strb[b]) scratch_d[8*b +: 8] = wr_data[8*b +: 8];
                3'd2: if (wr_strb[0]) led_d = wr_data[LED_W-1:0];
                3'd4: w1c = wr_strb[0] && wr_data[0];
                3'd5: if (wr_strb[0]) irq_en_d = wr_data[0];
                default: ;
            endcase
        end
        // A new event outranks a simultaneous clear.
        irq_stat_d = evt_in || (irq_stat_q && !w1c);
    end

    always_comb begin
        case (rd_off)
            3'd0:    rd_mux = VERSION;
            3'd1:    rd_mux = scratch_q;
            3'd2:    rd_mux = {{(32-LED_W){1'b0}}, led_q};
            3'd3:    rd_mux = cnt_q;
            3'd4:    rd_mux = {31'd0, irq_stat_q};
            3'd5:    rd_mux = {31'd0, irq_en_q};
            default: rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: if (cpu_if_arvalid) begin
                r_state_d = R_DATA;
                rdata_d   = rd_mux;
                rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
            end
            R_DATA:  if (cpu_if_rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            wr_off_q   <= 3'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            bresp_q    <= RESP_OKAY;
            rdata_q    <= 32'd0;
            rresp_q    <= RESP_OKAY;
            scratch_q  <= 32'd0;
            led_q      <= '0;
            cnt_q      <= 32'd0;
            irq_stat_q <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_out_q  <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            wr_off_q   <= wr_off_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            scratch_q  <= scratch_d;
            led_q      <= led_d;
            cnt_q      <= cnt_q + 32'd1;
            irq_stat_q <= irq_stat_d;
            irq_en_q   <= irq_en_d;
            irq_out_q  <= irq_stat_q && irq_en_q;
        end
    end

endmodule
